// File: rtl/mult_div_pkg.sv
// Definitions shared by the sequential multiplier and divider: controller
// states, default widths and the radix-2 Booth recoding codes.
package mult_div_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = 6;

   // {Q[0], q_m1} pairs that trigger an add or subtract of the multiplicand
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then an arithmetic right shift of {acc, Q, q_m1}.
module booth_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH:0]   m,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);

   logic [WIDTH:0] sum;

   // Recode the low multiplier bit pair and form acc +/- M at WIDTH+1 bits
   always_comb begin
      // NOTE: sum gets a value before the case so no path through the block leaves it unassigned (no latch).
      sum = acc;
      case ({q[0], q_m1})
         BOOTH_ADD: sum = acc + m;
         BOOTH_SUB: sum = acc - m;
         default:   sum = acc;
      endcase
   end

   // Arithmetic shift: sign of the sum is replicated into the top bit
   assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
   assign q_next    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential signed Booth multiplier answering the CPU's mult_in/mult_out
// start/stop handshake; one Booth iteration per clock, product on HI/LO.
module booth_mult_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mult_in,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             mult_out,
   output logic             busy
);

   state_t           state, state_next;
   logic [WIDTH:0]   acc, m_reg, acc_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic             q_m1, q_m1_next;
   logic [CNT_W-1:0] cnt;
   logic             last_iter;

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc       (acc),
      .m         (m_reg),
      .q         (q_reg),
      .q_m1      (q_m1),
      .acc_next  (acc_next),
      .q_next    (q_next),
      .q_m1_next (q_m1_next)
   );

   // State register; reset low at the clock edge forces IDLE
   always_ff @(posedge clock) begin
      // NOTE: registers use <= so every flop samples pre-edge values, whatever the statement order.
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state: accept only in IDLE, finish on the WIDTH-th iteration
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mult_in)   state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load operands on accept, iterate in RUN, capture the product
   always_ff @(posedge clock) begin
      if (!reset) begin
         m_reg <= '0;
         acc   <= '0;
         q_reg <= '0;
         q_m1  <= 1'b0;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mult_in) begin
                  m_reg <= {A[WIDTH-1], A};
                  acc   <= '0;
                  q_reg <= B;
                  q_m1  <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               acc  <= acc_next;
               q_reg <= q_next;
               q_m1 <= q_m1_next;
               cnt  <= cnt + CNT_W'(1);
               if (last_iter) begin
                  HI <= acc_next[WIDTH-1:0];
                  LO <= q_next;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs decode the state register only
   assign mult_out = (state == DONE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: the stimulus process pushes the
// hand-computed product at each accepted start, the monitor pops and compares
// on every mult_out pulse, including the 32-cycle latency.
module tb_booth_mult_unit;

   localparam int W = 32;
   localparam int LAT = 32;

   typedef struct {
      logic [2*W-1:0] prod;
      int             acc_cyc;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         mult_in = 1'b0;
   logic [W-1:0] HI, LO;
   logic         mult_out, busy;

   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;
   int   last_acc = 0;
   exp_t sb[$];

   booth_mult_unit dut (
      .clock    (clock),
      .reset    (reset),
      .A        (A),
      .B        (B),
      .mult_in  (mult_in),
      .HI       (HI),
      .LO       (LO),
      .mult_out (mult_out),
      .busy     (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every mult_out must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (mult_out) begin
         if (sb.size() == 0) begin
            check("unexpected_mult_out", {HI, LO}, '0);
            n_total++;
            $display("FAIL spurious_mult_out: got pulse, expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", {HI, LO}, e.prod);
            check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
            check("busy_in_done", 64'(busy), 64'd1);
         end
      end
   end

   // Wait (bounded) for a negedge with busy low; always advances at least one cycle
   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (!busy) return;
      end
      check("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_negedge_cyc(input int target);
      for (int i = 0; i < 200 && cyc < target; i++) @(negedge clock);
   endtask

   // Issue a start in the next idle cycle; push the expectation if one is due
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_done, input logic [2*W-1:0] prod);
      exp_t e;
      wait_idle();
      A = a;
      B = b;
      mult_in = 1'b1;
      @(posedge clock);
      #1;
      mult_in = 1'b0;
      A = $urandom;
      B = $urandom;
      last_acc = cyc;
      if (expect_done) begin
         e.prod = prod;
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
   endtask

   initial begin
      int busy_cnt;
      int acc0;

      // Reset held two cycles, then ten idle cycles
      repeat (2) @(negedge clock);
      check("reset_hilo", {HI, LO}, '0);
      check("reset_flags", 64'({mult_out, busy}), 64'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_hilo", {HI, LO}, '0);
         check("idle_flags", 64'({mult_out, busy}), 64'd0);
      end

      // 7 * -3, with busy length
      start(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (busy) busy_cnt++;
         else break;
      end
      check("busy_cycles", 64'(busy_cnt), 64'd33);

      // Extremes
      start(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      start(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);

      // Busy protection: extra requests at cycles 10 and 32 after acceptance
      start(32'd5, 32'd6, 1'b1, 64'd30);
      acc0 = last_acc;
      wait_negedge_cyc(acc0 + 9);
      A = 32'd9; B = 32'd9; mult_in = 1'b1;
      @(negedge clock);
      mult_in = 1'b0;
      wait_negedge_cyc(acc0 + 31);
      A = 32'd9; B = 32'd9; mult_in = 1'b1;
      repeat (2) @(negedge clock);
      mult_in = 1'b0;
      check("idle_after_protect", 64'(busy), 64'd0);
      start(32'd9, 32'd9, 1'b1, 64'd81);

      // Back-to-back: -1 * -1, then -8 * 8 on the first IDLE cycle after DONE
      start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
      for (int i = 0; i < 100 && !mult_out; i++) @(negedge clock);
      check("b2b_done_seen", 64'(mult_out), 64'd1);
      acc0 = cyc;
      start(32'hFFFF_FFF8, 32'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0);
      check("b2b_accept_edge", 64'(last_acc - acc0), 64'd2);
      check("b2b_busy", 64'(busy), 64'd1);
      check("b2b_hold_early", {HI, LO}, 64'd1);
      wait_negedge_cyc(last_acc + 31);
      check("b2b_hold_late", {HI, LO}, 64'd1);

      // Reset in the middle of 123 * 456; no result may follow
      start(32'd123, 32'd456, 1'b0, '0);
      acc0 = last_acc;
      wait_negedge_cyc(acc0 + 14);
      reset = 1'b0;
      @(negedge clock);
      check("abort_hilo", {HI, LO}, '0);
      check("abort_flags", 64'({mult_out, busy}), 64'd0);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      check("abort_idle", 64'({mult_out, busy}), 64'd0);

      repeat (5) @(negedge clock);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
